// File: rtl/integer_root_operation_pkg.sv
// Shared arithmetic definitions for the integer root block and its sibling
// exponentiation block: FSM encoding, root width helper, multiplier latency.
package integer_root_operation_pkg;

  localparam int unsigned DEFAULT_MULT_DELAY = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SETUP_BIT = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    MUL_CHECK = 3'd5,
    DONE      = 3'd6
  } root_state_t;

  // Any root of degree >= 2 of a data_width-bit value fits in this many bits.
  function automatic int unsigned root_width(input int unsigned data_width);
    return (data_width + 1) / 2;
  endfunction

endpackage

// File: rtl/integer_root_operation_multiplier.sv
// Fixed-latency pipelined multiplier: product valid MULT_DELAY cycles after issue.
module pipelined_multiplier
  import integer_root_operation_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MULT_DELAY = DEFAULT_MULT_DELAY
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  output logic [2*DATA_WIDTH-1:0] prod
);

  logic [MULT_DELAY-1:0]   valid_pipe;
  logic [2*DATA_WIDTH-1:0] prod_pipe [MULT_DELAY];

  // Only the valid flags are reset; data stages are qualified by them.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= in_valid;
      for (int unsigned i = 1; i < MULT_DELAY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    prod_pipe[0] <= {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    for (int unsigned i = 1; i < MULT_DELAY; i++) begin
      prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  assign out_valid = valid_pipe[MULT_DELAY-1];
  assign prod      = prod_pipe[MULT_DELAY-1];

endmodule

// File: rtl/integer_root_operation.sv
// Integer root r = floor(y^(1/e)) by MSB-first bit-serial search, powering each
// candidate through the pipelined multiplier; also reports whether r^e == y.
module integer_root_operation
  import integer_root_operation_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned EXPONENT_WIDTH = 3,
  parameter int unsigned MULT_DELAY     = DEFAULT_MULT_DELAY
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     inp_value,
  input  logic [EXPONENT_WIDTH-1:0] inp_exponent,
  output logic                      busy,
  output logic                      output_ready,
  output logic [DATA_WIDTH-1:0]     out_value,
  output logic                      out_exact,
  output logic                      out_error
);

  localparam int unsigned ROOT_WIDTH = root_width(DATA_WIDTH);
  localparam int unsigned BIT_W      = (ROOT_WIDTH > 1) ? $clog2(ROOT_WIDTH) : 1;

  root_state_t               state;
  logic [DATA_WIDTH-1:0]     y_reg;
  logic [EXPONENT_WIDTH-1:0] e_reg;
  logic [EXPONENT_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0]     root;
  logic [DATA_WIDTH-1:0]     cand;
  logic [DATA_WIDTH-1:0]     acc;
  logic [BIT_W-1:0]          bit_idx;
  logic                      exact;
  logic                      error_flag;
  logic [2*DATA_WIDTH-1:0]   prod_reg;
  logic [DATA_WIDTH-1:0]     next_cand;
  logic                      mul_in_valid;
  logic                      mul_out_valid;
  logic [2*DATA_WIDTH-1:0]   mul_prod;

  assign next_cand = root | (DATA_WIDTH'(1) << bit_idx);

  always_comb begin
    mul_in_valid = 1'b0;
    if (state == MUL_ISSUE) mul_in_valid = 1'b1;
  end

  pipelined_multiplier #(
    .DATA_WIDTH (DATA_WIDTH),
    .MULT_DELAY (MULT_DELAY)
  ) u_mult (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (mul_in_valid),
    .a         (acc),
    .b         (cand),
    .out_valid (mul_out_valid),
    .prod      (mul_prod)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      y_reg        <= '0;
      e_reg        <= '0;
      remaining    <= '0;
      root         <= '0;
      cand         <= '0;
      acc          <= '0;
      bit_idx      <= '0;
      exact        <= 1'b0;
      error_flag   <= 1'b0;
      prod_reg     <= '0;
      busy         <= 1'b0;
      output_ready <= 1'b0;
      out_value    <= '0;
      out_exact    <= 1'b0;
      out_error    <= 1'b0;
    end else begin
      output_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            y_reg      <= inp_value;
            e_reg      <= inp_exponent;
            error_flag <= 1'b0;
            exact      <= 1'b0;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          root <= '0;
          if (e_reg == '0) begin
            error_flag <= 1'b1;
            state      <= DONE;
          end else if (e_reg == EXPONENT_WIDTH'(1)) begin
            root  <= y_reg;
            exact <= 1'b1;
            state <= DONE;
          end else if (y_reg == '0) begin
            exact <= 1'b1;
            state <= DONE;
          end else begin
            bit_idx <= BIT_W'(ROOT_WIDTH - 1);
            state   <= SETUP_BIT;
          end
        end
        SETUP_BIT: begin
          // A candidate already above y can only grow when powered: skip the multiplies.
          if (next_cand > y_reg) begin
            if (bit_idx == '0) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
            end
          end else begin
            cand      <= next_cand;
            acc       <= next_cand;
            remaining <= e_reg - EXPONENT_WIDTH'(1);
            state     <= MUL_ISSUE;
          end
        end
        MUL_ISSUE: state <= MUL_WAIT;
        MUL_WAIT: begin
          if (mul_out_valid) begin
            prod_reg <= mul_prod;
            state    <= MUL_CHECK;
          end
        end
        MUL_CHECK: begin
          if (prod_reg <= {{DATA_WIDTH{1'b0}}, y_reg} && remaining != EXPONENT_WIDTH'(1)) begin
            acc       <= prod_reg[DATA_WIDTH-1:0];
            remaining <= remaining - EXPONENT_WIDTH'(1);
            state     <= MUL_ISSUE;
          end else begin
            if (prod_reg <= {{DATA_WIDTH{1'b0}}, y_reg}) begin
              root  <= cand;
              exact <= (prod_reg == {{DATA_WIDTH{1'b0}}, y_reg});
            end
            if (bit_idx == '0) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx - BIT_W'(1);
              state   <= SETUP_BIT;
            end
          end
        end
        DONE: begin
          out_value    <= root;
          out_exact    <= exact;
          out_error    <= error_flag;
          output_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integer_root_operation.sv
// Directed self-checking bench for integer_root_operation (32-bit, MULT_DELAY 4).
module tb_integer_root_operation;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inp_value = '0;
  logic [2:0]  inp_exponent = '0;
  logic        busy;
  logic        output_ready;
  logic [31:0] out_value;
  logic        out_exact;
  logic        out_error;

  int checks = 0;
  int fails  = 0;
  int issues = 0;
  int per_bit [16];
  int lat;
  logic busy_first;
  logic busy_at_ready;

  integer_root_operation #(
    .DATA_WIDTH     (32),
    .EXPONENT_WIDTH (3),
    .MULT_DELAY     (4)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .inp_value    (inp_value),
    .inp_exponent (inp_exponent),
    .busy         (busy),
    .output_ready (output_ready),
    .out_value    (out_value),
    .out_exact    (out_exact),
    .out_error    (out_error)
  );

  always #5 clock = ~clock;

  // Counts multiplier issues, attributed to the bit being searched.
  always @(posedge clock) begin
    if (u_dut.u_mult.in_valid) begin
      issues = issues + 1;
      per_bit[u_dut.bit_idx] = per_bit[u_dut.bit_idx] + 1;
    end
  end

  // Starts an operation; lat = edges from the start-sampling edge (edge 1) to ready.
  task automatic run_op(input logic [31:0] y, input logic [2:0] e, input int budget);
    @(negedge clock);
    issues = 0;
    for (int i = 0; i < 16; i++) per_bit[i] = 0;
    inp_value    = y;
    inp_exponent = e;
    start        = 1'b1;
    lat          = -1;
    busy_first   = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock); #1;
      if (n == 1) begin
        start      = 1'b0;
        busy_first = busy;
      end
      if (output_ready) begin
        lat           = n;
        busy_at_ready = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (output_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%0b exp=0", output_ready); end
    checks++; if (out_value !== 32'd0) begin fails++; $display("FAIL reset_value got=%0d exp=0", out_value); end
    checks++; if (out_exact !== 1'b0) begin fails++; $display("FAIL reset_exact got=%0b exp=0", out_exact); end
    checks++; if (out_error !== 1'b0) begin fails++; $display("FAIL reset_error got=%0b exp=0", out_error); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_cube();
    int extra;
    run_op(32'd1000, 3'd3, 400);
    checks++; if (lat !== 109) begin fails++; $display("FAIL cube1000_latency got=%0d exp=109", lat); end
    checks++; if (out_value !== 32'd10) begin fails++; $display("FAIL cube1000_value got=%0d exp=10", out_value); end
    checks++; if (out_exact !== 1'b1) begin fails++; $display("FAIL cube1000_exact got=%0b exp=1", out_exact); end
    checks++; if (out_error !== 1'b0) begin fails++; $display("FAIL cube1000_error got=%0b exp=0", out_error); end
    checks++; if (issues !== 15) begin fails++; $display("FAIL cube1000_multiplies got=%0d exp=15", issues); end
    checks++; if (busy_first !== 1'b1) begin fails++; $display("FAIL cube1000_busy_after_start got=%0b exp=1", busy_first); end
    checks++; if (busy_at_ready !== 1'b0) begin fails++; $display("FAIL cube1000_busy_at_ready got=%0b exp=0", busy_at_ready); end
    extra = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (output_ready) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("FAIL cube1000_single_pulse got=%0d extra pulses exp=0", extra); end
    checks++; if (out_value !== 32'd10) begin fails++; $display("FAIL cube1000_hold got=%0d exp=10", out_value); end

    run_op(32'd999, 3'd3, 400);
    checks++; if (lat !== 109) begin fails++; $display("FAIL cube999_latency got=%0d exp=109", lat); end
    checks++; if (out_value !== 32'd9) begin fails++; $display("FAIL cube999_value got=%0d exp=9", out_value); end
    checks++; if (out_exact !== 1'b0) begin fails++; $display("FAIL cube999_exact got=%0b exp=0", out_exact); end
  endtask

  task automatic test_sqrt();
    run_op(32'hFFFFFFFF, 3'd2, 400);
    checks++; if (lat !== 115) begin fails++; $display("FAIL sqrt_max_latency got=%0d exp=115", lat); end
    checks++; if (out_value !== 32'd65535) begin fails++; $display("FAIL sqrt_max_value got=%0d exp=65535", out_value); end
    checks++; if (out_exact !== 1'b0) begin fails++; $display("FAIL sqrt_max_exact got=%0b exp=0", out_exact); end
    run_op(32'hFFFE0001, 3'd2, 400);
    checks++; if (out_value !== 32'd65535) begin fails++; $display("FAIL sqrt_sq_value got=%0d exp=65535", out_value); end
    checks++; if (out_exact !== 1'b1) begin fails++; $display("FAIL sqrt_sq_exact got=%0b exp=1", out_exact); end
  endtask

  task automatic test_special();
    run_op(32'd12345, 3'd1, 50);
    checks++; if (lat !== 3) begin fails++; $display("FAIL e1_latency got=%0d exp=3", lat); end
    checks++; if (out_value !== 32'd12345) begin fails++; $display("FAIL e1_value got=%0d exp=12345", out_value); end
    checks++; if (out_exact !== 1'b1) begin fails++; $display("FAIL e1_exact got=%0b exp=1", out_exact); end
    checks++; if (out_error !== 1'b0) begin fails++; $display("FAIL e1_error got=%0b exp=0", out_error); end
    run_op(32'd77, 3'd0, 50);
    checks++; if (lat !== 3) begin fails++; $display("FAIL e0_latency got=%0d exp=3", lat); end
    checks++; if (out_value !== 32'd0) begin fails++; $display("FAIL e0_value got=%0d exp=0", out_value); end
    checks++; if (out_error !== 1'b1) begin fails++; $display("FAIL e0_error got=%0b exp=1", out_error); end
    checks++; if (out_exact !== 1'b0) begin fails++; $display("FAIL e0_exact got=%0b exp=0", out_exact); end
    run_op(32'd0, 3'd5, 50);
    checks++; if (lat !== 3) begin fails++; $display("FAIL y0_latency got=%0d exp=3", lat); end
    checks++; if (out_value !== 32'd0) begin fails++; $display("FAIL y0_value got=%0d exp=0", out_value); end
    checks++; if (out_exact !== 1'b1) begin fails++; $display("FAIL y0_exact got=%0b exp=1", out_exact); end
    checks++; if (out_error !== 1'b0) begin fails++; $display("FAIL y0_error got=%0b exp=0", out_error); end
    checks++; if (issues !== 0) begin fails++; $display("FAIL y0_multiplies got=%0d exp=0", issues); end
  endtask

  task automatic test_seventh();
    int exp_m [16];
    exp_m = '{4, 6, 3, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_op(32'd128, 3'd7, 400);
    checks++; if (lat !== 133) begin fails++; $display("FAIL root7_latency got=%0d exp=133", lat); end
    checks++; if (out_value !== 32'd2) begin fails++; $display("FAIL root7_value got=%0d exp=2", out_value); end
    checks++; if (out_exact !== 1'b1) begin fails++; $display("FAIL root7_exact got=%0b exp=1", out_exact); end
    checks++; if (issues !== 19) begin fails++; $display("FAIL root7_multiplies got=%0d exp=19", issues); end
    for (int b = 0; b < 16; b++) begin
      checks++;
      if (per_bit[b] !== exp_m[b]) begin
        fails++; $display("FAIL root7_mb bit=%0d got=%0d exp=%0d", b, per_bit[b], exp_m[b]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    @(negedge clock);
    inp_value = 32'd1000; inp_exponent = 3'd3; start = 1'b1;
    lat = -1; pulses = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clock); #1;
      if (n == 1) start = 1'b0;
      if (n == 6) begin inp_value = 32'd5; inp_exponent = 3'd2; start = 1'b1; end
      if (n == 7) start = 1'b0;
      if (output_ready) begin
        pulses++;
        if (lat < 0) lat = n;
      end
    end
    checks++; if (lat !== 109) begin fails++; $display("FAIL busy_ignore_latency got=%0d exp=109", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
    checks++; if (out_value !== 32'd10) begin fails++; $display("FAIL busy_ignore_value got=%0d exp=10", out_value); end
    checks++; if (out_exact !== 1'b1) begin fails++; $display("FAIL busy_ignore_exact got=%0b exp=1", out_exact); end
  endtask

  task automatic test_reset_midop();
    int pulses;
    @(negedge clock);
    inp_value = 32'd1000; inp_exponent = 3'd3; start = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 250; n++) begin
      @(posedge clock); #1;
      if (n == 1) start = 1'b0;
      if (n == 20) reset = 1'b1;
      if (n == 21) reset = 1'b0;
      if (output_ready) pulses++;
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
    checks++; if (out_value !== 32'd0) begin fails++; $display("FAIL midreset_value got=%0d exp=0", out_value); end
    checks++; if (out_exact !== 1'b0) begin fails++; $display("FAIL midreset_exact got=%0b exp=0", out_exact); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
    run_op(32'd999, 3'd3, 400);
    checks++; if (lat !== 109) begin fails++; $display("FAIL after_reset_latency got=%0d exp=109", lat); end
    checks++; if (out_value !== 32'd9) begin fails++; $display("FAIL after_reset_value got=%0d exp=9", out_value); end
    checks++; if (out_exact !== 1'b0) begin fails++; $display("FAIL after_reset_exact got=%0b exp=0", out_exact); end
  endtask

  initial begin
    test_reset();
    test_cube();
    test_sqrt();
    test_special();
    test_seventh();
    test_busy_ignore();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
